// File: rtl/fir_pkg.sv
// Shared constants, state encoding and output arithmetic for the single-MAC FIR engine.
package fir_pkg;
    localparam int NTAPS = 256;
    localparam int AW    = 8;
    localparam int DW    = 24;
    localparam int CW    = 24;
    localparam int ACCW  = 56;
    localparam int OW    = 24;
    localparam int SHIFT = 23;
    localparam int PW    = DW + CW;

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_MAC   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    typedef enum logic [2:0] {
        CLEAR = ST_CLEAR,
        IDLE  = ST_IDLE,
        MAC   = ST_MAC,
        DRAIN = ST_DRAIN,
        OUT   = ST_OUT
    } state_t;

    typedef logic signed [DW-1:0]   sample_t;
    typedef logic signed [CW-1:0]   coef_t;
    typedef logic signed [PW-1:0]   prod_t;
    typedef logic signed [ACCW-1:0] acc_t;

    localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 32'sd1);
    localparam acc_t          ACC_ONE    = acc_t'(64'sd1);
    localparam acc_t          ROUND_HALF = ACC_ONE <<< (SHIFT - 32'sd1);
    localparam acc_t          OUT_MAX    = (ACC_ONE <<< (OW - 32'sd1)) - ACC_ONE;
    localparam acc_t          OUT_MIN    = -(ACC_ONE <<< (OW - 32'sd1));

    // Round half up, arithmetic shift, then clamp into the signed output range.
    function automatic logic signed [OW-1:0] round_sat(input acc_t acc);
        acc_t rnd;
        rnd = (acc + ROUND_HALF) >>> SHIFT;
        if (rnd > OUT_MAX) begin
            return OW'(OUT_MAX);
        end else if (rnd < OUT_MIN) begin
            return OW'(OUT_MIN);
        end else begin
            return OW'(rnd);
        end
    endfunction
endpackage

// File: rtl/fir_sample_ram.sv
// Circular delay-line storage: one synchronous write port, one registered read port.
module fir_sample_ram
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    output logic signed [DW-1:0] rdata
);
    sample_t mem_r [NTAPS];

    // Write port; contents are not reset, the engine's CLEAR pass zeroes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port with one cycle of latency.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end
endmodule

// File: rtl/fir_mac_engine.sv
// Single-MAC FIR core: one accepted sample walks all taps against a registered coefficient ROM.
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [OW-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy
);
    state_t          state_r;
    logic [AW-1:0]   wp_r;
    logic [AW-1:0]   clr_cnt_r;
    logic [AW-1:0]   coef_addr_r;
    logic [1:0]      drain_cnt_r;
    logic            in_ready_r;
    logic            busy_r;
    logic            out_valid_r;
    logic signed [OW-1:0] out_data_r;
    logic            rd_vld_r;
    logic            prod_vld_r;
    prod_t           prod_r;
    acc_t            acc_r;

    logic            accept_s;
    logic            ram_we_s;
    logic            ram_re_s;
    logic [AW-1:0]   ram_waddr_s;
    logic [AW-1:0]   ram_raddr_s;
    sample_t         ram_wdata_s;
    sample_t         ram_rdata_s;

    fir_sample_ram u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (ram_re_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Delay-line port control; tap k reads the sample written k accepts ago.
    always_comb begin
        accept_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_waddr_s = wp_r;
        ram_wdata_s = '0;
        ram_raddr_s = wp_r - coef_addr_r;
        case (state_r)
            CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_cnt_r;
            end
            IDLE: begin
                accept_s    = in_valid & in_ready_r;
                ram_we_s    = accept_s;
                ram_wdata_s = in_data;
            end
            MAC: begin
                ram_re_s = 1'b1;
            end
            default: begin
                ram_re_s = 1'b0;
            end
        endcase
    end

    // Sequencer: clear pass, tap walk, pipeline drain, then the output strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= CLEAR;
            wp_r        <= '0;
            clr_cnt_r   <= '0;
            coef_addr_r <= '0;
            drain_cnt_r <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + AW'(1'b1);
                    if (clr_cnt_r == LAST_TAP) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= MAC;
                        coef_addr_r <= '0;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                MAC: begin
                    if (coef_addr_r == LAST_TAP) begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= '0;
                    end else begin
                        coef_addr_r <= coef_addr_r + AW'(1'b1);
                    end
                end
                DRAIN: begin
                    // Two cycles let the last read, product and accumulate land.
                    if (drain_cnt_r == 2'd1) begin
                        state_r <= OUT;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                OUT: begin
                    out_data_r  <= round_sat(acc_r);
                    out_valid_r <= 1'b1;
                    wp_r        <= wp_r + AW'(1'b1);
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r    <= CLEAR;
                    clr_cnt_r  <= '0;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b1;
                end
            endcase
        end
    end

    // Multiply-accumulate pipeline: read/ROM data -> product register -> accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_r   <= 1'b0;
            prod_vld_r <= 1'b0;
            prod_r     <= '0;
            acc_r      <= '0;
        end else begin
            rd_vld_r   <= ram_re_s;
            prod_vld_r <= rd_vld_r;
            if (rd_vld_r) begin
                prod_r <= prod_t'(ram_rdata_s) * prod_t'(coef_data);
            end
            if (accept_s) begin
                acc_r <= '0;
            end else if (prod_vld_r) begin
                acc_r <= acc_r + acc_t'(prod_r);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign coef_addr = coef_addr_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with a convolution model and a registered coefficient ROM.
module tb_fir_mac_engine;
    logic               clk;
    logic               reset;
    logic signed [23:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         coef_addr;
    logic signed [23:0] coef_data;
    logic signed [23:0] out_data;
    logic               out_valid;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    logic signed [23:0] rom [256];

    typedef struct {
        longint val;
        int     t;
    } exp_t;
    exp_t   expq [$];
    longint hist [$];
    longint last_out = 0;

    fir_mac_engine dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered coefficient ROM: data follows the address by one cycle.
    always @(posedge clk) coef_data <= rom[coef_addr];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // y[n] = sat(round(sum_k coef[k] * x[n-k])) over the samples since the last reset.
    function automatic longint model_out();
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < hist.size(); k++) acc += hist[k] * longint'(rom[k]);
        r = (acc + 64'sd4194304) >>> 23;
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
        return r;
    endfunction

    task automatic set_rom(input int mode, input logic signed [23:0] val);
        for (int k = 0; k < 256; k++) begin
            if (mode == 0) rom[k] = 24'(2 * k + 2);
            else if (mode == 1) rom[k] = (k == 0) ? 24'sd1 : 24'sd0;
            else rom[k] = val;
        end
    endtask

    // Compare process: every cycle out of reset the outputs are checked against the model.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!reset) begin
            expq.delete();
            hist.delete();
            last_out = 0;
        end else begin
            check("busy_vs_ready", longint'(busy), longint'(!in_ready));
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_out_valid", longint'(out_valid), 64'sd0);
                end else begin
                    e = expq.pop_front();
                    check("model_out_data", longint'(out_data), e.val);
                    check("out_latency", longint'(ncyc - e.t), 64'sd260);
                    last_out = e.val;
                end
            end else begin
                check("out_hold", longint'(out_data), last_out);
            end
            if (in_valid && in_ready) begin
                hist.push_front(longint'(in_data));
                if (hist.size() > 256) void'(hist.pop_back());
                e.val = model_out();
                e.t   = ncyc;
                expq.push_back(e);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 600; w++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        int n;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_data", longint'(out_data), 64'sd0);
        check("rst_out_valid", longint'(out_valid), 64'sd0);
        check("rst_in_ready", longint'(in_ready), 64'sd0);
        check("rst_busy", longint'(busy), 64'sd1);
        check("rst_coef_addr", longint'(coef_addr), 64'sd0);
        @(posedge clk); #1;
        reset = 1'b1;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("clear_cycles", longint'(n), 64'sd256);
        check("idle_busy", longint'(busy), 64'sd0);
        check("idle_out_data", longint'(out_data), 64'sd0);
    endtask

    task automatic send_wait(input logic signed [23:0] s, output longint got);
        bit ok;
        got = 0;
        @(posedge clk); #1;
        in_data  = s;
        in_valid = 1'b1;
        wait_ready(ok);
        check("send_accept", longint'(ok), 64'sd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 600; w++) begin
            @(negedge clk);
            if (out_valid) begin
                got = longint'(out_data);
                ok  = 1'b1;
                break;
            end
        end
        check("send_out_valid", longint'(ok), 64'sd1);
    endtask

    // in_valid stays high throughout; each new sample appears only after the previous accept.
    task automatic stream(input int n);
        bit ok;
        int cnt;
        int last;
        cnt  = 0;
        last = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 24'($urandom());
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int w = 0; w < 600; w++) begin
                @(negedge clk);
                cnt++;
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("stream_accept", longint'(ok), 64'sd1);
            if (!ok) break;
            if (i > 0) check("accept_spacing", longint'(cnt - last), 64'sd260);
            last = cnt;
            @(posedge clk); #1;
            in_data = 24'($urandom());
        end
        in_valid = 1'b0;
    endtask

    initial begin
        longint got;
        bit     ok;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        set_rom(0, 24'sd0);
        do_reset();

        for (int n = 0; n < 16; n++) begin
            send_wait((n == 0) ? 24'sh400000 : 24'sh000000, got);
            check("impulse_tap", got, longint'(n + 1));
        end

        stream(244);
        repeat (300) @(negedge clk);

        @(posedge clk); #1;
        in_data  = 24'sh123456;
        in_valid = 1'b1;
        wait_ready(ok);
        check("midmac_accept", longint'(ok), 64'sd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (99) @(negedge clk);
        do_reset();
        send_wait(24'sh400000, got);
        check("post_reset_impulse", got, 64'sd1);

        set_rom(1, 24'sd0);
        send_wait(24'sh400000, got);
        check("round_half_pos", got, 64'sd1);
        send_wait(24'sh3FFFFF, got);
        check("round_below_half", got, 64'sd0);
        send_wait(24'shC00000, got);
        check("round_half_neg", got, 64'sd0);
        send_wait(24'shBFFFFF, got);
        check("round_below_neg_half", got, -64'sd1);

        set_rom(2, 24'sh7FFFFF);
        do_reset();
        send_wait(24'sh7FFFFF, got);
        check("fullscale_one_tap", got, 64'sd8388606);
        send_wait(24'sh7FFFFF, got);
        check("sat_positive", got, 64'sd8388607);

        set_rom(2, 24'sh800000);
        do_reset();
        send_wait(24'sh800000, got);
        check("sat_neg_times_neg", got, 64'sd8388607);

        set_rom(2, 24'sh7FFFFF);
        do_reset();
        send_wait(24'sh800000, got);
        check("neg_one_tap", got, -64'sd8388607);
        send_wait(24'sh800000, got);
        check("sat_negative", got, -64'sd8388608);

        repeat (5) @(negedge clk);
        check("pending_outputs", longint'(expq.size()), 64'sd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
